// File: rtl/anim_frame_sequencer.sv
// Sprite animation frame sequencer: steps a frame index through NUM_FRAMES
// frames after a trigger, holding each frame for Hold_Cycles+1 clocks.
module anim_frame_sequencer #(
    parameter int FRAME_W     = 2,
    parameter int NUM_FRAMES  = 2,
    parameter int FIRST_FRAME = 2,
    parameter int IDLE_FRAME  = 1,
    parameter int DONE_FRAME  = 0,
    parameter int HOLD_W      = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Trigger,
    input  logic               Abort,
    input  logic               Loop,
    input  logic [HOLD_W-1:0]  Hold_Cycles,
    output logic [FRAME_W-1:0] frame,
    output logic               busy,
    output logic               done_pulse
);

    localparam logic [FRAME_W-1:0] FIRST_F  = FRAME_W'(FIRST_FRAME);
    localparam logic [FRAME_W-1:0] IDLE_F   = FRAME_W'(IDLE_FRAME);
    localparam logic [FRAME_W-1:0] DONE_F   = FRAME_W'(DONE_FRAME);
    localparam logic [FRAME_W-1:0] LAST_IDX = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [FRAME_W-1:0] IDX_ONE  = FRAME_W'(1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE = HOLD_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DONE
    } state_t;

    state_t              state;
    logic [FRAME_W-1:0]  idx;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_q;
    logic                loop_q;

    // Outputs are computed alongside the next state so that frame, busy and
    // done_pulse are plain flops with no path back to the inputs.
    always_ff @(posedge Clk) begin
        // NOTE: every register here, including the latched hold/loop settings,
        // gets a defined reset value; nothing relies on power-up contents.
        if (Reset) begin
            state      <= IDLE;
            idx        <= '0;
            hold_cnt   <= '0;
            hold_q     <= '0;
            loop_q     <= 1'b0;
            frame      <= IDLE_F;
            busy       <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout so every branch reads
            // the pre-edge values of state, idx and hold_cnt.
            done_pulse <= 1'b0;
            if (Abort) begin
                state    <= IDLE;
                idx      <= '0;
                hold_cnt <= '0;
                frame    <= IDLE_F;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (Trigger) begin
                            state    <= PLAY;
                            idx      <= '0;
                            hold_cnt <= '0;
                            hold_q   <= Hold_Cycles;
                            loop_q   <= Loop;
                            frame    <= FIRST_F;
                            busy     <= 1'b1;
                        end
                    end
                    PLAY: begin
                        // The counter resets on the match, so it never runs past hold_q.
                        if (hold_cnt == hold_q) begin
                            hold_cnt <= '0;
                            if (idx < LAST_IDX) begin
                                idx   <= idx + IDX_ONE;
                                frame <= FIRST_F + idx + IDX_ONE;
                            end else if (loop_q) begin
                                idx   <= '0;
                                frame <= FIRST_F;
                            end else begin
                                state      <= DONE;
                                frame      <= DONE_F;
                                busy       <= 1'b0;
                                done_pulse <= 1'b1;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        frame <= IDLE_F;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/anim_frame_sequencer.md
Name: anim_frame_sequencer

Overview:
- Parametrised successor to the screen/animation frame FSMs in the display path.
- Steps a frame index through a configurable run of sprite frames after a button trigger.
- Each frame is held for a programmable number of cycles.
- Supports one-shot or looping playback, abort, and re-trigger from the done state.
- Output `frame` feeds the sprite ROM address mux in the VGA color mapper.

Parameters:
- FRAME_W, 2: width of frame output.
- NUM_FRAMES, 2: number of animation frames played per run (1..2^FRAME_W).
- FIRST_FRAME, 2: frame value of the first animation frame.
- IDLE_FRAME, 1: frame value shown while idle.
- DONE_FRAME, 0: frame value shown after a one-shot run completes.
- HOLD_W, 8: width of the per-frame hold count.

Ports:
- Clk, input, 1: system clock. Single clock domain.
- Reset, input, 1: synchronous, active-high reset.
- Trigger, input, 1: start request (e.g. J_Press). Level-sampled each cycle.
- Abort, input, 1: return to idle.
- Loop, input, 1: 1 = restart at first frame after the last frame; 0 = one-shot.
- Hold_Cycles, input, HOLD_W: each frame is displayed Hold_Cycles+1 cycles.
- frame, output, FRAME_W: current frame index.
- busy, output, 1: high while in PLAY.
- done_pulse, output, 1: single-cycle pulse on entry to DONE.

Behaviour:
- One clock. Reset is synchronous and active-high on Clk/Reset. Reset dominates all other inputs.
- Reset values:
  - state = IDLE
  - frame = IDLE_FRAME
  - busy = 0
  - done_pulse = 0
  - frame index idx = 0
  - hold counter = 0
  - latched hold = 0
  - latched loop = 0
- States:
  - IDLE: frame = IDLE_FRAME, busy = 0.
    - Trigger=1 and Abort=0 → PLAY.
    - On this transition: idx ← 0, hold counter ← 0, latch Hold_Cycles and Loop.
  - PLAY: frame = FIRST_FRAME + idx, truncated to FRAME_W (wraps modulo 2^FRAME_W). busy = 1.
    - Hold counter increments every cycle.
    - When counter == latched hold: counter ← 0.
      - If idx < NUM_FRAMES-1: idx ← idx+1.
      - Else if latched loop: idx ← 0, stay in PLAY.
      - Else → DONE.
    - Trigger is ignored in PLAY (no restart).
  - DONE: frame = DONE_FRAME, busy = 0. done_pulse = 1 only in the first DONE cycle.
    - Trigger=1 → PLAY with the same latching as from IDLE (re-trigger).
    - Otherwise stay in DONE.
- Abort: in any state, Abort=1 → IDLE next cycle, idx and counter cleared. Abort has priority over Trigger and over frame advance. done_pulse is not raised on abort.
- Latency:
  - Trigger sampled at edge k → first animation frame visible from edge k+1.
  - A one-shot run occupies exactly NUM_FRAMES × (Hold_Cycles+1) cycles in PLAY, then DONE.
- Hold_Cycles and Loop are sampled only on entry to PLAY. Mid-run changes have no effect until the next trigger.
- Hold_Cycles = 0 → each frame lasts one cycle. Hold_Cycles = all-ones → 2^HOLD_W cycles. The counter must not overflow past the latched value.
- NUM_FRAMES = 1: single frame held, then DONE, or a repeat of that frame if looping.
- All outputs are registered or decoded purely from registered state. No combinational path from inputs to outputs.
- Reset asserted mid-PLAY → IDLE values next cycle. No done_pulse.

Test Plan:
- Defaults, Hold_Cycles=0, Loop=0, Trigger pulsed 1 cycle from IDLE:
  - frame sequence 1 → 2 → 3 → 0 (one cycle each).
  - busy high for exactly 2 cycles.
  - done_pulse high for 1 cycle coincident with first frame=0.
  - frame then stays 0.
- FRAME_W=3, NUM_FRAMES=4, FIRST_FRAME=6, Hold_Cycles=2, Loop=0:
  - frames 6,7,0,1, each for 3 cycles (wrap check), then DONE_FRAME.
- Loop=1 at trigger, Hold_Cycles=1, defaults:
  - frame pattern 2,2,3,3,2,2,3,3,… with busy constant 1.
  - Driving Loop=0 mid-run does not stop playback.
  - Abort=1 → frame=1, busy=0 next cycle, no done_pulse.
- Re-trigger: in DONE, Trigger=1 with Hold_Cycles=0 → frame 2 next cycle. Trigger held high during PLAY causes no restart.
- Trigger=1 and Abort=1 same cycle in IDLE → stays IDLE.
- Reset asserted during PLAY → frame=1, busy=0, done_pulse=0 on the following cycle.
- Hold_Cycles=8'hFF, NUM_FRAMES=2 → first frame held exactly 256 cycles, second 256, then DONE.
